// File: rtl/pll_clk_sequencer_pkg.sv
// Shared types and helpers for the PLL clock sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pll_clk_sequencer_pkg;

    // Encodings are visible on the state output port, so they are fixed here.
    typedef enum logic [2:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_FILTER     = 3'd2,
        ST_ENABLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } seq_state_t;

    // Counter width for a counter that must distinguish `terminal` values
    // (0 .. terminal-1). Never narrower than one bit.
    function automatic int cnt_w(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/lock_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module lock_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_clk_sequencer.sv
// PLL bring-up sequencer: reset pulse, lock wait with timeout/retry, lock filter, staggered enclk.
// Latency: all outputs registered; pll_lock reaches the FSM after 2 cycles of synchronisation.
// Backpressure: none; relock_req is a single-cycle request accepted in every state.
//
// Ports:
//   clkin, reset_n      controller clock and async active-low reset
//   pll_lock            raw PLL lock (asynchronous)
//   clk_mask            per-channel permission to run
//   relock_req          restart the whole sequence, clears fault and lost_lock
//   pll_reset, enclk    drive the PLL
//   ready, fault        status; lost_lock is sticky until relock_req
//   retry_cnt, state    debug visibility of the attempt count and FSM state
module pll_clk_sequencer
    import pll_clk_sequencer_pkg::*;
#(
    parameter int NUM_CLK      = 3,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILT    = 64,
    parameter int EN_GAP       = 8,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clkin,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic [NUM_CLK-1:0] clk_mask,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic               ready,
    output logic               fault,
    output logic               lost_lock,
    output logic [7:0]         retry_cnt,
    output logic [2:0]         state
);

    localparam int RST_W  = cnt_w(RST_CYCLES);
    localparam int TMR_W  = cnt_w(LOCK_TIMEOUT);
    localparam int FILT_W = cnt_w(LOCK_FILT);
    localparam int GAP_W  = cnt_w(EN_GAP);
    localparam int IDX_W  = cnt_w(NUM_CLK);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(EN_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CLK - 1);
    localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);

    logic lock_s;

    lock_sync2 u_lock_sync (
        .clk   (clkin),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    seq_state_t         state_q,     state_nxt;
    logic [RST_W-1:0]   rst_cnt_q,   rst_cnt_nxt;
    logic [TMR_W-1:0]   tmr_q,       tmr_nxt;
    logic [FILT_W-1:0]  filt_cnt_q,  filt_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_nxt;
    logic [IDX_W-1:0]   idx_q,       idx_nxt;
    logic [NUM_CLK-1:0] enclk_q,     enclk_nxt;
    logic [7:0]         retry_q,     retry_nxt;
    logic               lost_q,      lost_nxt;
    logic               pll_reset_q, pll_reset_nxt;
    logic               ready_q,     ready_nxt;
    logic               fault_q,     fault_nxt;

    logic               in_lock_wait;
    logic               next_lock_wait;
    logic               timed_out;
    logic               lock_drop;
    logic [IDX_W-1:0]   idx_inc;

    always_comb begin
        state_nxt    = state_q;
        rst_cnt_nxt  = rst_cnt_q;
        filt_cnt_nxt = filt_cnt_q;
        gap_cnt_nxt  = gap_cnt_q;
        idx_nxt      = idx_q;
        enclk_nxt    = enclk_q;
        retry_nxt    = retry_q;
        lost_nxt     = lost_q;
        idx_inc      = idx_q + 1'b1;

        in_lock_wait = (state_q == ST_WAIT_LOCK) || (state_q == ST_FILTER);
        timed_out    = in_lock_wait && (tmr_q == TMR_LAST);
        lock_drop    = ((state_q == ST_ENABLE) || (state_q == ST_RUN)) && !lock_s;

        // Event priority: relock request, then lock loss, then timeout,
        // then ordinary per-state progress.
        if (relock_req) begin
            state_nxt   = ST_RST_ASSERT;
            rst_cnt_nxt = '0;
            retry_nxt   = '0;
            lost_nxt    = 1'b0;
            enclk_nxt   = '0;
        end else if (lock_drop) begin
            // Lock loss is not a failed attempt, so retry_cnt is left alone.
            state_nxt   = ST_RST_ASSERT;
            rst_cnt_nxt = '0;
            lost_nxt    = 1'b1;
            enclk_nxt   = '0;
        end else if (timed_out) begin
            enclk_nxt = '0;
            if (retry_q == RETRY_MAX) begin
                state_nxt = ST_FAULT;
            end else begin
                retry_nxt   = retry_q + 8'd1;
                state_nxt   = ST_RST_ASSERT;
                rst_cnt_nxt = '0;
            end
        end else begin
            unique case (state_q)
                ST_RST_ASSERT: begin
                    enclk_nxt = '0;
                    if (rst_cnt_q == RST_LAST) begin
                        state_nxt   = ST_WAIT_LOCK;
                        rst_cnt_nxt = '0;
                    end else begin
                        rst_cnt_nxt = rst_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt    = ST_FILTER;
                        filt_cnt_nxt = '0;
                    end
                end
                ST_FILTER: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (filt_cnt_q == FILT_LAST) begin
                        // Slot 0 is taken on the entry edge itself.
                        state_nxt    = ST_ENABLE;
                        idx_nxt      = '0;
                        gap_cnt_nxt  = '0;
                        enclk_nxt[0] = clk_mask[0];
                    end else begin
                        filt_cnt_nxt = filt_cnt_q + 1'b1;
                    end
                end
                ST_ENABLE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_nxt = '0;
                        if (idx_q == IDX_LAST) begin
                            state_nxt = ST_RUN;
                            retry_nxt = '0;
                        end else begin
                            idx_nxt            = idx_inc;
                            enclk_nxt[idx_inc] = clk_mask[idx_inc];
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    enclk_nxt = clk_mask;
                end
                ST_FAULT: begin
                    enclk_nxt = '0;
                end
                default: begin
                    state_nxt   = ST_RST_ASSERT;
                    rst_cnt_nxt = '0;
                    enclk_nxt   = '0;
                end
            endcase
        end

        // The timeout spans WAIT_LOCK and FILTER together, so lock bounce
        // between them keeps the timer running; any other path clears it.
        next_lock_wait = (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_FILTER);
        if (in_lock_wait && next_lock_wait) begin
            tmr_nxt = (tmr_q == TMR_LAST) ? tmr_q : tmr_q + 1'b1;
        end else begin
            tmr_nxt = '0;
        end

        pll_reset_nxt = (state_nxt == ST_RST_ASSERT) || (state_nxt == ST_FAULT);
        ready_nxt     = (state_nxt == ST_RUN);
        fault_nxt     = (state_nxt == ST_FAULT);
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RST_ASSERT;
            rst_cnt_q   <= '0;
            tmr_q       <= '0;
            filt_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            idx_q       <= '0;
            enclk_q     <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            rst_cnt_q   <= rst_cnt_nxt;
            tmr_q       <= tmr_nxt;
            filt_cnt_q  <= filt_cnt_nxt;
            gap_cnt_q   <= gap_cnt_nxt;
            idx_q       <= idx_nxt;
            enclk_q     <= enclk_nxt;
            retry_q     <= retry_nxt;
            lost_q      <= lost_nxt;
            pll_reset_q <= pll_reset_nxt;
            ready_q     <= ready_nxt;
            fault_q     <= fault_nxt;
        end
    end

    assign pll_reset = pll_reset_q;
    assign enclk     = enclk_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign lost_lock = lost_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed bench for pll_clk_sequencer with a phase-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_clk_sequencer;

    localparam int NUM_CLK      = 3;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_FILT    = 8;
    localparam int EN_GAP       = 2;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRY    = 2;

    logic               clkin = 1'b0;
    logic               reset_n;
    logic               pll_lock;
    logic [NUM_CLK-1:0] clk_mask;
    logic               relock_req;
    logic               pll_reset;
    logic [NUM_CLK-1:0] enclk;
    logic               ready;
    logic               fault;
    logic               lost_lock;
    logic [7:0]         retry_cnt;
    logic [2:0]         state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clkin = ~clkin;

    pll_clk_sequencer #(
        .NUM_CLK      (NUM_CLK),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_FILT    (LOCK_FILT),
        .EN_GAP       (EN_GAP),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .clk_mask   (clk_mask),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .enclk      (enclk),
        .ready      (ready),
        .fault      (fault),
        .lost_lock  (lost_lock),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    // Reference model: phase number (0..5 as on the state port), cycles
    // spent in the phase, time since the PLL reset was released, length of
    // the current run of synchronised lock, attempts used, sticky loss flag,
    // channel enables and the two synchroniser stages.
    typedef struct {
        int               ph;
        int               ph_cyc;
        int               tmr;
        int               run_len;
        int               retries;
        bit               lost;
        bit [NUM_CLK-1:0] en;
        bit               s1;
        bit               s2;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = 0; r.ph_cyc = 0; r.tmr = 0; r.run_len = 0; r.retries = 0;
        r.lost = 1'b0; r.en = '0; r.s1 = 1'b0; r.s2 = 1'b0;
        return r;
    endfunction

    function automatic mdl_t model_step(mdl_t c, bit lk_in, bit rr, bit [NUM_CLK-1:0] mask);
        mdl_t n;
        bit   lk;
        int   slot;
        n    = c;
        lk   = c.s2;
        n.s1 = lk_in;
        n.s2 = c.s1;
        if (rr) begin
            n.ph = 0; n.ph_cyc = 0; n.retries = 0; n.lost = 1'b0; n.en = '0;
        end else if ((c.ph == 3 || c.ph == 4) && !lk) begin
            n.ph = 0; n.ph_cyc = 0; n.lost = 1'b1; n.en = '0;
        end else if ((c.ph == 1 || c.ph == 2) && c.tmr == LOCK_TIMEOUT - 1) begin
            if (c.retries == MAX_RETRY) begin
                n.ph = 5;
            end else begin
                n.retries = c.retries + 1; n.ph = 0; n.ph_cyc = 0;
            end
        end else begin
            case (c.ph)
                0: begin
                    n.ph_cyc = c.ph_cyc + 1;
                    if (n.ph_cyc == RST_CYCLES) begin n.ph = 1; n.tmr = 0; end
                end
                1: begin
                    n.tmr = c.tmr + 1;
                    if (lk) begin n.ph = 2; n.run_len = 0; end
                end
                2: begin
                    n.tmr = c.tmr + 1;
                    if (!lk) n.ph = 1;
                    else begin
                        n.run_len = c.run_len + 1;
                        if (n.run_len == LOCK_FILT) begin
                            n.ph = 3; n.ph_cyc = 0; n.en[0] = mask[0];
                        end
                    end
                end
                3: begin
                    n.ph_cyc = c.ph_cyc + 1;
                    if (n.ph_cyc == NUM_CLK * EN_GAP) begin
                        n.ph = 4; n.retries = 0;
                    end else if (n.ph_cyc % EN_GAP == 0) begin
                        slot = n.ph_cyc / EN_GAP;
                        n.en[slot] = mask[slot];
                    end
                end
                4: n.en = mask;
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clkin or negedge reset_n) begin
        if (!reset_n) m <= mdl_reset();
        else          m <= model_step(m, pll_lock, relock_req, clk_mask);
    end

    always @(posedge clkin or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clkin) begin
        chk("m_state",     32'(state),     32'(m.ph));
        chk("m_pll_reset", 32'(pll_reset), 32'(m.ph == 0 || m.ph == 5));
        chk("m_enclk",     32'(enclk),     32'(m.en));
        chk("m_ready",     32'(ready),     32'(m.ph == 4));
        chk("m_fault",     32'(fault),     32'(m.ph == 5));
        chk("m_lost_lock", 32'(lost_lock), 32'(m.lost));
        chk("m_retry_cnt", 32'(retry_cnt), 32'(m.retries));
    end

    task automatic to_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clkin);
            guard++;
        end
        if (cyc != n) begin
            total++;
            bad++;
            $display("FAIL to_cyc: reached cycle %0d, wanted %0d", cyc, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        clk_mask   = 3'b111;
        relock_req = 1'b0;
        repeat (3) @(negedge clkin);
        reset_n = 1'b1;

        // Reset values.
        chk("rst_state", 32'(state), 0);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_enclk", 32'(enclk), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_retry", 32'(retry_cnt), 0);

        // Nominal bring-up, lock sampled at edge 10.
        to_cyc(3);  chk("nom_pll_reset_c3", 32'(pll_reset), 1);
        to_cyc(4);  chk("nom_pll_reset_c4", 32'(pll_reset), 0); chk("nom_state_c4", 32'(state), 1);
        to_cyc(9);  pll_lock = 1'b1;
        to_cyc(19); chk("nom_state_c19", 32'(state), 2); chk("nom_enclk_c19", 32'(enclk), 0);
        to_cyc(20); chk("nom_state_c20", 32'(state), 3); chk("nom_enclk_c20", 32'(enclk), 3'b001);
        to_cyc(21); chk("nom_enclk_c21", 32'(enclk), 3'b001);
        to_cyc(22); chk("nom_enclk_c22", 32'(enclk), 3'b011);
        to_cyc(24); chk("nom_enclk_c24", 32'(enclk), 3'b111);
        to_cyc(25); chk("nom_ready_c25", 32'(ready), 0);
        to_cyc(26); chk("nom_ready_c26", 32'(ready), 1); chk("nom_state_c26", 32'(state), 4);

        // Lock loss in RUN.
        to_cyc(30); pll_lock = 1'b0;
        to_cyc(32); chk("loss_ready_c32", 32'(ready), 1);
        to_cyc(33);
        chk("loss_enclk", 32'(enclk), 0);
        chk("loss_ready", 32'(ready), 0);
        chk("loss_lost", 32'(lost_lock), 1);
        chk("loss_state", 32'(state), 0);
        pll_lock = 1'b1;
        to_cyc(52);
        chk("relock_ready", 32'(ready), 1);
        chk("relock_lost_sticky", 32'(lost_lock), 1);

        // Mask change in RUN takes one cycle.
        to_cyc(53); clk_mask = 3'b011; chk("mask_run_c53", 32'(enclk), 3'b111);
        to_cyc(54); chk("mask_run_c54", 32'(enclk), 3'b011);

        // relock_req coinciding with lock loss.
        to_cyc(56); pll_lock = 1'b0;
        to_cyc(58); chk("coin_state_c58", 32'(state), 4); chk("coin_lost_c58", 32'(lost_lock), 1);
        relock_req = 1'b1;
        to_cyc(59); relock_req = 1'b0;
        chk("coin_state", 32'(state), 0);
        chk("coin_lost", 32'(lost_lock), 0);
        chk("coin_retry", 32'(retry_cnt), 0);
        chk("coin_enclk", 32'(enclk), 0);

        // Timeout / retry / fault with lock held low.
        to_cyc(94);  chk("to_state_c94", 32'(state), 1); chk("to_retry_c94", 32'(retry_cnt), 0);
        to_cyc(95);  chk("to_state_c95", 32'(state), 0); chk("to_retry_c95", 32'(retry_cnt), 1);
        chk("to_pll_reset_c95", 32'(pll_reset), 1);
        to_cyc(99);  chk("to_pll_reset_c99", 32'(pll_reset), 0);
        to_cyc(131); chk("to_retry_c131", 32'(retry_cnt), 2); chk("to_state_c131", 32'(state), 0);
        to_cyc(166); chk("to_state_c166", 32'(state), 1);
        to_cyc(167);
        chk("fault_state", 32'(state), 5);
        chk("fault_flag", 32'(fault), 1);
        chk("fault_pll_reset", 32'(pll_reset), 1);
        chk("fault_retry", 32'(retry_cnt), 2);
        to_cyc(175); chk("fault_hold", 32'(fault), 1);
        relock_req = 1'b1;
        to_cyc(176); relock_req = 1'b0;
        chk("clr_fault", 32'(fault), 0);
        chk("clr_retry", 32'(retry_cnt), 0);
        chk("clr_state", 32'(state), 0);

        // Lock bounce at filter count 5; timer keeps running and expires.
        to_cyc(195); pll_lock = 1'b1;
        to_cyc(198); chk("bnc_state_c198", 32'(state), 2);
        to_cyc(201); pll_lock = 1'b0;
        to_cyc(202); pll_lock = 1'b1;
        to_cyc(203); chk("bnc_state_c203", 32'(state), 2);
        to_cyc(204); chk("bnc_state_c204", 32'(state), 1);
        to_cyc(205); chk("bnc_state_c205", 32'(state), 2);
        to_cyc(211); chk("bnc_state_c211", 32'(state), 2);
        to_cyc(212); chk("bnc_state_c212", 32'(state), 0); chk("bnc_retry_c212", 32'(retry_cnt), 1);
        to_cyc(231);
        chk("bnc_run_state", 32'(state), 4);
        chk("bnc_run_ready", 32'(ready), 1);
        chk("bnc_run_retry", 32'(retry_cnt), 0);

        // Masked channel during ENABLE still consumes its slot.
        to_cyc(235); clk_mask = 3'b101; relock_req = 1'b1;
        to_cyc(236); relock_req = 1'b0; chk("msk_state_c236", 32'(state), 0);
        to_cyc(248); chk("msk_state_c248", 32'(state), 2);
        to_cyc(249); chk("msk_state_c249", 32'(state), 3); chk("msk_enclk_c249", 32'(enclk), 3'b001);
        to_cyc(251); chk("msk_enclk_c251", 32'(enclk), 3'b001);
        to_cyc(253); chk("msk_enclk_c253", 32'(enclk), 3'b101);
        to_cyc(254); chk("msk_state_c254", 32'(state), 3);
        to_cyc(255);
        chk("msk_state_c255", 32'(state), 4);
        chk("msk_enclk_c255", 32'(enclk), 3'b101);
        chk("msk_ready_c255", 32'(ready), 1);

        // Mid-sequence reset acts immediately.
        to_cyc(260);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_pll_reset", 32'(pll_reset), 1);
        chk("arst_enclk", 32'(enclk), 0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_fault", 32'(fault), 0);
        chk("arst_lost", 32'(lost_lock), 0);
        chk("arst_retry", 32'(retry_cnt), 0);
        repeat (2) @(negedge clkin);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
